sram_lsu: RTL
=============

# sram_lsu

Load/store initiator that drives the core's single-port data SRAM. It accepts one byte-addressed RISC-V load or store request per transaction over a valid/ready handshake. It converts each request into a word address, a byte-lane write mask and lane-replicated write data for the SRAM. For loads, it extracts the addressed byte or halfword from the SRAM's registered read data and sign- or zero-extends it. It sits between the pipeline's MEM stage and the data memory instance.

## Interface
- `LENGTH`, 8192: memory size in bytes (power of two ≥ 8).
- `AW`, `$clog2(LENGTH/4)`: word-address width; derived, not overridden.
- `NBITS`, 32: data width; only 32 is supported.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address; bits above `AW+1` are ignored.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.
- `mem_addr`  out  AW  SRAM word address.
- `mem_data`  out  32  SRAM write data.
- `mem_we`  out  4  SRAM byte write enables; bit i controls bits `[8i+7:8i]`.
- `mem_rdata`  in  32  SRAM read data; valid one cycle after the address is sampled.

## Operation
States are IDLE, ACCESS, WAIT and RESP. `req_ready` = (state == IDLE).

- **IDLE**
  - A handshake (`req_valid & req_ready`) latches `we`, `funct3` and `addr[1:0]`.
  - It also registers `mem_addr = req_addr[AW+1:2]`, `mem_data` and the pending lane mask.
  - A valid request goes to ACCESS. An erroneous request goes to RESP with the error flag set and causes no memory access.
- **ACCESS**
  - `mem_we` = lane mask for stores; 0 for loads.
  - The SRAM samples address and data at the end of this cycle.
  - A store goes to RESP; a load goes to WAIT.
- **WAIT**
  - `mem_rdata` is valid in this cycle.
  - Shift right by `8*addr[1:0]` for bytes or `16*addr[1]` for halves, then sign- or zero-extend per `funct3`.
  - The result is registered into `rsp_rdata`. Next state: RESP.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle. There is no response backpressure. Next state: IDLE.

Lane rules:
- Byte: `mem_data = {4{wdata[7:0]}}`, `mem_we = 4'b0001 << addr[1:0]`.
- Half: `mem_data = {2{wdata[15:0]}}`, `mem_we = addr[1] ? 4'b1100 : 4'b0011`.
- Word: `mem_data = wdata`, `mem_we = 4'b1111`.

Errors (`rsp_err = 1`, `rsp_rdata = 0`):
- `funct3` ∈ {011, 110, 111}.
- A store with `funct3` 100 or 101.
- Misalignment, only when the configuration macro below is defined.

Other rules:
- `mem_we` is 0 in every state except ACCESS of a store.
- `mem_addr` and `mem_data` hold their last values between transactions.

## Timing
- Handshake at edge n:
  - Store: `mem_we` active in cycle n+1; `rsp_valid` in cycle n+2.
  - Load: `rsp_valid` in cycle n+3.
  - Error: `rsp_valid` in cycle n+1.
- Throughput: a new request can be accepted in the cycle after RESP.
- Reset (asynchronous, any state):
  - state = IDLE, so `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_addr`, `mem_data` and `mem_we` all = 0.
  - An in-flight transaction is dropped and never produces `rsp_valid`. A store that is reset during ACCESS has `mem_we` forced to 0 immediately.
- `req_*` inputs are ignored whenever `req_ready` = 0.

## Configuration
- `SRAM_LSU_MISALIGN_ERR_EN` defined:
  - A half access with `addr[0] = 1`, or a word access with `addr[1:0] ≠ 0`, is an error.
  - It gets the error response; no SRAM access occurs.
- Not defined:
  - No misalignment errors.
  - A half access ignores `addr[0]`; a word access ignores `addr[1:0]`. The access proceeds at the aligned location.

## Test plan
- **Word round trip:** SW 0xDEADBEEF at 0x10, then LW 0x10. Require `mem_addr` = 4 and `mem_we` = 1111 in the store's ACCESS cycle; `rsp_rdata` = 0xDEADBEEF three cycles after the load handshake.
- **Byte lanes and extension:** SB 0xA5 at 0x5. Require `mem_we` = 0010 and `mem_data` = 0xA5A5A5A5. Then LB 0x5 → 0xFFFFFFA5; LBU 0x5 → 0x000000A5.
- **Half lanes and extension:** SH 0x8001 at 0x6. Require `mem_we` = 1100. Then LH 0x6 → 0xFFFF8001; LHU 0x6 → 0x00008001.
- **Misalignment:** LW at 0x12.
  - With the macro: `rsp_valid` and `rsp_err` = 1 one cycle after the handshake, `rsp_rdata` = 0, and `mem_we` stays 0.
  - Without the macro: returns the word at 0x10.
- **Invalid funct3:** a request with `funct3` = 011, and a store with `funct3` = 100. Each gives `rsp_err` = 1 and no `mem_we` activity.
- **Reset mid-load:** assert `resetn` low during WAIT. All outputs go to 0 immediately and `req_ready` = 1 after release. No `rsp_valid` pulse ever occurs for that load, and the next LW completes normally.

Source files
------------

// File: rtl/sram_lsu.sv
// sram_lsu: load/store initiator for the core's single-port data SRAM.
// Turns one byte-addressed RISC-V load/store per transaction into a word
// address, byte-lane write mask and lane-replicated write data, then
// extracts and sign/zero-extends load data from the SRAM's registered output.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE; req_* are ignored
// otherwise. rsp_valid is a one-cycle pulse with no backpressure; rsp_err
// and rsp_rdata are meaningful only while rsp_valid is high.
//
// Optional feature: define SRAM_LSU_MISALIGN_ERR_EN to reject misaligned
// half/word accesses with an error response. When undefined, misaligned
// accesses silently use the naturally aligned location.
module sram_lsu #(
  parameter  int LENGTH = 8192,
  parameter  int NBITS  = 32,
  localparam int AW     = $clog2(LENGTH / 4)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [NBITS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [NBITS-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    mem_addr,
  output logic [NBITS-1:0] mem_data,
  output logic [3:0]       mem_we,
  input  logic [NBITS-1:0] mem_rdata,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [NBITS-1:0] r_rsp_rdata;
  logic [AW-1:0]    r_mem_addr;
  logic [NBITS-1:0] r_mem_data;
  logic [3:0]       r_mem_we;

  logic [3:0]       w_mask;
  logic [NBITS-1:0] w_wdata;
  logic             w_err;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [NBITS-1:0] w_load;
  logic             w_unused_addr;

  // Address bits beyond the memory size are deliberately ignored.
  assign w_unused_addr = ^req_addr[31:AW+2];

`ifdef SRAM_LSU_MISALIGN_ERR_EN
  logic w_misalign;
  // Half must be 2-byte aligned, word must be 4-byte aligned.
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

  // Decode the incoming request into lane mask, replicated data and error.
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = req_wdata;
    w_err   = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: begin
        w_mask  = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        w_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        w_mask  = 4'b1111;
        w_wdata = req_wdata;
      end
      default: w_err = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (req_we && req_funct3[2]) w_err = 1'b1;
`ifdef SRAM_LSU_MISALIGN_ERR_EN
    if (w_misalign) w_err = 1'b1;
`endif
  end

  // Select the addressed byte/half from the SRAM word and extend it.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'b0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_off       <= req_addr[1:0];
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_err;
            if (w_err) begin
              // Rejected requests never touch the SRAM.
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_mem_addr <= req_addr[AW+1:2];
              r_mem_data <= w_wdata;
              r_mem_we   <= req_we ? w_mask : 4'b0000;
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_mem_we <= 4'b0000;
          if (r_we) begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_rsp_rdata <= w_load;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_we      = r_mem_we;
  assign o_dbg_state = r_state;

endmodule
